// File: rtl/adder_slice_sequencer_if.sv
// adder_slice_sequencer_if: start/done request bus for the multi-cycle wide adder.
interface adder_slice_sequencer_if #(parameter int W = 64);
    logic         start;
    logic         sub;
    logic         c_in;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    logic         overflow;
    modport master (output start, sub, c_in, a, b, input busy, done, sum, c_out, overflow);
    modport slave (input start, sub, c_in, a, b, output busy, done, sum, c_out, overflow);
endinterface

// File: rtl/adder_slice_sequencer.sv
// adder_slice_sequencer: one SLICE_W-bit lookahead slice reused NUM_SLICES times for a wide add/sub.
// Define ADDSEQ_EARLY_DONE_EN to stop early once the remaining slices are known to be zero.
module adder_slice_sequencer #(
    parameter int SLICE_W    = 16,
    parameter int NUM_SLICES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    adder_slice_sequencer_if.slave  bus
);
    localparam int W  = SLICE_W * NUM_SLICES;
    localparam int G  = SLICE_W / 4;
    localparam int IW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_n;
    logic [W-1:0]   a_reg, b_reg, sum_r, sum_new;
    logic [IW-1:0]  idx;
    logic           carry, c_out_r, ovf_r, busy, done;
    logic [SLICE_W-1:0] sa, sb, sp, sg, ss;
    logic [G:0]     gc;
    logic           co, last, early, finish;

    assign sa = a_reg[idx*SLICE_W +: SLICE_W];
    assign sb = b_reg[idx*SLICE_W +: SLICE_W];
    assign sp = sa ^ sb;
    assign sg = sa & sb;
    assign gc[0] = carry;
    assign co = gc[G];

    // Each 4-bit unit resolves its carries in parallel from generate/propagate; units chain by group carry.
    for (genvar g = 0; g < G; g++) begin : g_cla
        logic [3:0] p, k;
        logic [4:0] c;
        assign p = sp[4*g +: 4];
        assign k = sg[4*g +: 4];
        assign c[0] = gc[g];
        assign c[1] = k[0] | (p[0] & c[0]);
        assign c[2] = k[1] | (p[1] & k[0]) | (p[1] & p[0] & c[0]);
        assign c[3] = k[2] | (p[2] & k[1]) | (p[2] & p[1] & k[0]) | (p[2] & p[1] & p[0] & c[0]);
        assign c[4] = k[3] | (p[3] & k[2]) | (p[3] & p[2] & k[1]) | (p[3] & p[2] & p[1] & k[0])
                    | (&p & c[0]);
        assign gc[g+1] = c[4];
        assign ss[4*g +: 4] = p ^ c[3:0];
    end

    assign last = idx == IW'(NUM_SLICES - 1);

`ifdef ADDSEQ_EARLY_DONE_EN
    logic sub_r;
    assign early = !last && !co && !sub_r && (((a_reg | b_reg) >> ((idx + 1) * SLICE_W)) == '0);
`else
    assign early = 1'b0;
`endif

    assign finish = last || early;

    always_comb begin
        sum_new = sum_r;
        sum_new[idx*SLICE_W +: SLICE_W] = ss;
        sum_new = early ? (sum_new & ~({W{1'b1}} << ((idx + 1) * SLICE_W))) : sum_new;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = (state == IDLE) ? (bus.start ? RUN : IDLE)
                : (state == RUN)  ? (finish ? DONE : RUN)
                :                   IDLE;
    end

    always_comb begin
        busy = state != IDLE;
        done = state == DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sum_r   <= '0;
            idx     <= '0;
            carry   <= 1'b0;
            c_out_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            a_reg <= bus.a;
            b_reg <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub | bus.c_in;
            idx   <= '0;
        end else if (state == RUN) begin
            sum_r <= sum_new;
            carry <= co;
            idx   <= idx + 1'b1;
            if (finish) begin
                c_out_r <= early ? 1'b0 : co;
                ovf_r   <= early ? 1'b0 : (a_reg[W-1] ^ b_reg[W-1] ^ sum_new[W-1] ^ co);
            end
        end
    end

`ifdef ADDSEQ_EARLY_DONE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            sub_r <= 1'b0;
        else if (state == IDLE && bus.start) sub_r <= bus.sub;
    end
`endif

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.sum      = sum_r;
    assign bus.c_out    = c_out_r;
    assign bus.overflow = ovf_r;
endmodule

// File: doc/adder_slice_sequencer.md
Name: adder_slice_sequencer

Overview:
- Multi-cycle wide adder/subtractor. One SLICE_W-bit carry-lookahead slice (built from 4-bit lookahead carry units) is reused across NUM_SLICES cycles to produce a NUM_SLICES*SLICE_W-bit result.
- Sits beside the ALU and serves 64-bit add/sub and address-extension operations with a start/done handshake.
- Holds the inter-slice carry in a register between cycles.

Parameters:
- SLICE_W, 16, width of the shared lookahead adder slice; must be a multiple of 4.
- NUM_SLICES, 4, number of slices per operation; total width W = SLICE_W*NUM_SLICES.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  1 = a - b, 0 = a + b + c_in; latched with start.
- c_in  input  1  carry in for add; ignored when sub=1.
- a  input  W  operand A; latched with start.
- b  input  W  operand B; latched with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when result is valid.
- sum  output  W  result; holds until the next accepted start.
- c_out  output  1  carry out of bit W-1.
- overflow  output  1  signed overflow of the W-bit operation.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, sum=0, c_out=0, overflow=0; slice index=0; carry register=0; operand registers=0. An operation interrupted by reset is discarded and produces no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge latches a, b (b inverted when sub=1), and carry register = (sub ? 1 : c_in).
  - Same edge: index=0, state becomes RUN.
  - start=0: remain in IDLE, all outputs hold.
- RUN, one slice per edge:
  - sum[k*SLICE_W +: SLICE_W] = A_k + B'_k + carry_reg.
  - carry_reg = slice carry out; index = k+1.
  - When k = NUM_SLICES-1: state becomes DONE; c_out = slice carry out; overflow = carry into bit W-1 XOR carry out of bit W-1. Carry into bit W-1 = a[W-1]^b'[W-1]^sum[W-1].
- DONE: done=1 for exactly this cycle; next edge returns to IDLE.
- Latency: start sampled at edge E0, done high in the cycle after edge E(NUM_SLICES). Default is 5 cycles start-to-done.
- start while busy=1 is ignored, not queued. start held high through DONE is accepted on the first IDLE edge after it, giving back-to-back ops every NUM_SLICES+2 cycles.
- Input changes on a, b, sub, c_in after acceptance have no effect on the current operation.
- Slice-internal sums are modulo 2^SLICE_W. Only the final carry is exported.
- sum slices not yet written in RUN show the previous result's upper bits. Consumers read sum only when done=1 or later.
- The sub=1 result is the two's complement difference. c_out=1 means no borrow (a >= b unsigned).

Optional Feature:
- Macro: ADDSEQ_EARLY_DONE_EN.
- With the macro, after writing slice k (k < NUM_SLICES-1), terminate early when all of the following hold:
  - the carry out of slice k is 0;
  - every remaining slice of latched A and B' is all-zero;
  - sub=0.
- On early termination: all remaining sum slices are written to 0 on the same edge, c_out=0, overflow=0, and state becomes DONE.
- Latency then equals k+2 cycles.
- Without the macro, RUN always runs exactly NUM_SLICES cycles and there is no zero-detect logic.

Test Plan:
- Basic add: a=0x0000_0000_FFFF_FFFF, b=0x1, c_in=0, sub=0 -> done in cycle 5; sum=0x0000_0001_0000_0000, c_out=0, overflow=0. Busy is high in cycles 1-5.
- Full carry ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=0, c_in=1 -> sum=0, c_out=1, overflow=0. Verifies the carry register crosses all 4 slices.
- Subtract and signed overflow:
  - a=0x8000_0000_0000_0000, b=1, sub=1 -> sum=0x7FFF_FFFF_FFFF_FFFF, c_out=1, overflow=1.
  - a=3, b=5, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, c_out=0.
- Handshake: start pulsed again at cycles 2 and 4 during the first op -> ignored, exactly one done. start held high continuously -> dones exactly 6 cycles apart, results matching the operands latched at each acceptance.
- Reset mid-op: rst asserted asynchronously during RUN index 2 -> immediately busy=0, sum=0, c_out=0, overflow=0. No done pulse. The next start runs a full-latency correct op.
- Early done (macro on): a=0x1234, b=0x1, sub=0 -> done in cycle 2, sum=0x1235. Same stimulus with the macro off -> done in cycle 5, same sum.
